latch_sr_write_controller: RTL
==============================

Name: latch_sr_write_controller

Overview:
- Sequences writes into a bank of NUM_LATCHES gated SR latches. The latches share one set line and one reset line; each latch has its own enable.
- Two requesters (A, B) share the bank through a round-robin arbiter.
- A Moore FSM issues each write as setup, enable pulse, hold. S and R are never both high, and S/R stay stable for the whole enable window.
- Sits between lab control logic and the latch bank.

Parameters:
NUM_LATCHES, 4, number of latches driven (1..2**INDEX_WIDTH)
INDEX_WIDTH, 2, width of the latch index fields
ENABLE_CYCLES, 2, enable pulse width in clock cycles (>=1)

Ports:
clock  input  1  system clock, rising edge
reset_  input  1  asynchronous, active-low reset
request_a  input  1  requester A write request, level, held until grant_a
index_a  input  INDEX_WIDTH  latch index for A
value_a  input  1  1 = set latch, 0 = reset latch (A)
grant_a  output  1  one-cycle pulse: A's command accepted
request_b  input  1  requester B write request
index_b  input  INDEX_WIDTH  latch index for B
value_b  input  1  value for B
grant_b  output  1  one-cycle pulse: B's command accepted
latch_enable  output  NUM_LATCHES  one-hot enable to the latch bank
latch_set  output  1  shared set line
latch_reset  output  1  shared reset line
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in HOLD

Behaviour:
- Clock and reset: one clock (clock). reset_ is asynchronous and active-low.
- Reset values (while reset_=0):
  - state=IDLE
  - all outputs 0
  - last winner = B, so A wins the first tie
  - A reset_ assertion in any state aborts the write immediately. No done pulse is produced. latch_enable drops to 0 asynchronously.
- All outputs are registered or decoded from state only (Moore). There is no combinational path from inputs to outputs.
- States: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - Outputs are all 0.
  - If any request is sampled high, the controller latches the winner's index and value into cmd registers, sets last-winner, and moves to SETUP.
- Arbitration:
  - Only one requester high: that requester wins.
  - Both high: the requester not granted last time wins. The loser keeps its request asserted and is served next.
- SETUP: 1 cycle.
  - grant_x=1 for the winner.
  - busy=1.
  - latch_set=cmd_value and latch_reset=~cmd_value.
  - latch_enable=0.
- PULSE: ENABLE_CYCLES cycles, counted by a down-counter of width clog2(ENABLE_CYCLES+1).
  - latch_enable[cmd_index]=1.
  - set/reset held.
- HOLD: 1 cycle.
  - latch_enable=0.
  - set/reset held.
  - done=1.
  - Next state is IDLE.
- Idle lines: latch_set and latch_reset return to 0 in IDLE.
- Timing (accept edge = edge 0):
  - grant in cycle 1
  - enable in cycles 2..1+ENABLE_CYCLES
  - done in cycle 2+ENABLE_CYCLES
  - IDLE in cycle 3+ENABLE_CYCLES
  - A request sampled in that IDLE cycle starts the next write. Minimum spacing between writes is 3+ENABLE_CYCLES cycles.
- Request sampling: requests are sampled only in IDLE. A request still high during SETUP after grant is ignored. Requesters must deassert after seeing grant. A request re-raised afterwards is treated as a new command.
- Inputs captured at accept: index and value changes after the accept edge have no effect on the current write.
- Out-of-range index (cmd_index >= NUM_LATCHES): the full sequence runs and done pulses, but no latch_enable bit is asserted.
- Invariant: latch_set & latch_reset == 0 in every cycle, and latch_enable is at most one-hot.

Decomposition:
- Package latch_ctrl_pkg: state encoding constants (IDLE=2'd0, SETUP=2'd1, PULSE=2'd2, HOLD=2'd3) and requester id constants (REQ_A=1'b0, REQ_B=1'b1).
- Sub-module round_robin_arbiter_2: combinational 2-way winner select from the two requests and the last-winner register. The last-winner flop is owned by the controller.

Test Plan:
- Reset: reset_=0 for 3 cycles with requests high → all outputs 0; after release, A wins the first tie.
- Single write: A, index 2, value 1, ENABLE_CYCLES=2 → grant_a in cycle 1; latch_set=1 and latch_reset=0 for cycles 1–4; latch_enable=4'b0100 for cycles 2–3; done in cycle 4; IDLE in cycle 5.
- Tie: A and B both request (A idx 0 val 1, B idx 3 val 0) → A served first, then B accepted in the first IDLE cycle; latch_enable 4'b0001 then 4'b1000; latch_reset=1 only during B's write.
- Fairness: both requesters hold requests continuously for 4 writes → grants alternate A, B, A, B.
- Abort: reset_ pulled low during PULSE → latch_enable=0 immediately, no done pulse, busy=0, next write starts cleanly.
- Boundary: NUM_LATCHES=3 with index 3 → done still pulses and latch_enable stays 0; ENABLE_CYCLES=1 gives exactly one enable cycle.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : latch_ctrl_pkg
// Description : Shared state encoding and requester ids for the SR latch
//               write controller.
// Revision    : 1.0 - initial release
// ============================================================================
package latch_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/round_robin_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_arbiter_2
// Description : Combinational two-way round-robin winner select. The
//               last-winner flop lives in the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_arbiter_2
   import latch_ctrl_pkg::*;
(
   input  logic request_a,
   input  logic request_b,
   input  logic last_winner,
   output logic any_request,
   output logic winner
);

   // On a tie the requester that was not served last time wins.
   always_comb begin
      any_request = request_a | request_b;
      winner      = REQ_A;
      if (request_a && request_b) begin
         winner = (last_winner == REQ_A) ? REQ_B : REQ_A;
      end else if (request_b) begin
         winner = REQ_B;
      end
   end

endmodule
`default_nettype wire

// File: rtl/latch_sr_write_controller.sv
`default_nettype none
// ============================================================================
// Module      : latch_sr_write_controller
// Description : Sequences setup / enable pulse / hold writes into a bank of
//               gated SR latches for two round-robin arbitrated requesters.
//               All outputs decode from registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
module latch_sr_write_controller
   import latch_ctrl_pkg::*;
#(
   parameter int NUM_LATCHES   = 4,
   parameter int INDEX_WIDTH   = 2,
   parameter int ENABLE_CYCLES = 2
)(
   input  logic                   clock,
   input  logic                   reset_,
   input  logic                   request_a,
   input  logic [INDEX_WIDTH-1:0] index_a,
   input  logic                   value_a,
   output logic                   grant_a,
   input  logic                   request_b,
   input  logic [INDEX_WIDTH-1:0] index_b,
   input  logic                   value_b,
   output logic                   grant_b,
   output logic [NUM_LATCHES-1:0] latch_enable,
   output logic                   latch_set,
   output logic                   latch_reset,
   output logic                   busy,
   output logic                   done
);

   localparam int COUNT_WIDTH = $clog2(ENABLE_CYCLES + 1);
   localparam logic [COUNT_WIDTH-1:0] PULSE_LOAD = COUNT_WIDTH'(ENABLE_CYCLES - 1);

   state_t                 state;
   state_t                 next_state;
   logic [COUNT_WIDTH-1:0] pulse_count;
   logic [INDEX_WIDTH-1:0] cmd_index;
   logic                   cmd_value;
   logic                   cmd_winner;
   logic                   last_winner;
   logic                   any_request;
   logic                   winner;

   round_robin_arbiter_2 u_arbiter (
      .request_a   (request_a),
      .request_b   (request_b),
      .last_winner (last_winner),
      .any_request (any_request),
      .winner      (winner)
   );

   // State register; reset aborts any write in flight.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Capture the winning command at the accept edge so later input changes
   // cannot disturb the write in progress.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         cmd_index   <= '0;
         cmd_value   <= 1'b0;
         cmd_winner  <= REQ_A;
         last_winner <= REQ_B;
      end else if (state == IDLE && any_request) begin
         cmd_index   <= (winner == REQ_B) ? index_b : index_a;
         cmd_value   <= (winner == REQ_B) ? value_b : value_a;
         cmd_winner  <= winner;
         last_winner <= winner;
      end
   end

   // Enable-window down-counter: loaded in SETUP, expires at zero in PULSE.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         pulse_count <= '0;
      end else if (state == SETUP) begin
         pulse_count <= PULSE_LOAD;
      end else if (state == PULSE && pulse_count != '0) begin
         pulse_count <= pulse_count - 1'b1;
      end
   end

   // Next-state and Moore output decode.
   always_comb begin
      next_state  = state;
      grant_a     = 1'b0;
      grant_b     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      latch_set   = 1'b0;
      latch_reset = 1'b0;
      case (state)
         IDLE: begin
            if (any_request) begin
               next_state = SETUP;
            end
         end
         SETUP: begin
            busy        = 1'b1;
            grant_a     = (cmd_winner == REQ_A);
            grant_b     = (cmd_winner == REQ_B);
            latch_set   = cmd_value;
            latch_reset = ~cmd_value;
            next_state  = PULSE;
         end
         PULSE: begin
            busy        = 1'b1;
            latch_set   = cmd_value;
            latch_reset = ~cmd_value;
            if (pulse_count == '0) begin
               next_state = HOLD;
            end
         end
         HOLD: begin
            busy        = 1'b1;
            done        = 1'b1;
            latch_set   = cmd_value;
            latch_reset = ~cmd_value;
            next_state  = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // One-hot enable decode; an index beyond the bank matches no bit.
   generate
      for (genvar i = 0; i < NUM_LATCHES; i++) begin : g_enable
         assign latch_enable[i] = (state == PULSE) && (cmd_index == INDEX_WIDTH'(i));
      end
   endgenerate

endmodule
`default_nettype wire
